// File: rtl/wb_pkg.sv
// Shared types for the Wishbone initiator slice.
//   state_e   : sequencer state (IDLE, ACTIVE)
//   wb_rsp_t  : one registered beat response {dat, err, timeout, last}
//   sel_width : number of select lanes for a data width / lane granule
package wb_pkg;

  // Response data field width; widen this for buses wider than 32 bits.
  localparam int RSP_DAT_W = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  typedef struct packed {
    logic [RSP_DAT_W-1:0] dat;
    logic                 err;
    logic                 timeout;
    logic                 last;
  } wb_rsp_t;

  function automatic int sel_width(input int data_w, input int granule);
    return data_w / granule;
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Per-beat timeout counter.
//   clk_i, rst_i : clock, asynchronous active-low reset
//   clr_i        : restart the count (new beat or bus idle); wins over en_i
//   en_i         : the current beat waited another cycle without termination
//   expire_o     : this waiting cycle is the TIMEOUT_CYCLES-th one
// With TIMEOUT_CYCLES = 0 the counter is removed and expire_o is tied low.
module wb_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_tieoff;
      assign unused_tieoff = ^{clk_i, rst_i, clr_i, en_i};
      assign expire_o      = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
      logic [CW-1:0] cnt_q;

      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          cnt_q <= '0;
        end else if (clr_i) begin
          cnt_q <= '0;
        end else if (en_i) begin
          cnt_q <= cnt_q + CW'(1);
        end
      end

      // cnt_q counts waits already taken, so the edge that would bring it
      // to TIMEOUT_CYCLES is the expiring one: stb stays up exactly
      // TIMEOUT_CYCLES cycles.
      assign expire_o = en_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/wb_master_seq.sv
// Command-driven Wishbone classic initiator.
// Takes one command (we, adr, dat, sel, len) and runs a single classic
// cycle of len+1 beats with incrementing address, returning one response
// pulse per beat. A beat ends on ack_i, err_i (err wins, aborts the cycle)
// or after TIMEOUT_CYCLES unterminated cycles (aborts the cycle).
// Ports:
//   clk_i, rst_i           : clock, asynchronous active-low reset
//   cmd_valid_i/ready_o    : command handshake
//   cmd_we/adr/dat/sel/len : command fields, sampled only at acceptance
//   rsp_valid_o            : one-cycle response pulse
//   rsp_dat/err/timeout/last_o : response contents
//   cyc_o, stb_o, we_o, adr_o, dat_o, sel_o : Wishbone initiator outputs
//   ack_i, err_i, dat_i    : Wishbone terminations and read data
module wb_master_seq
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int GRANULE        = 8,
  parameter int LEN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic                          cmd_we_i,
  input  logic [ADDR_WIDTH-1:0]         cmd_adr_i,
  input  logic [DATA_WIDTH-1:0]         cmd_dat_i,
  input  logic [DATA_WIDTH/GRANULE-1:0] cmd_sel_i,
  input  logic [LEN_WIDTH-1:0]          cmd_len_i,
  output logic                          rsp_valid_o,
  output logic [DATA_WIDTH-1:0]         rsp_dat_o,
  output logic                          rsp_err_o,
  output logic                          rsp_timeout_o,
  output logic                          rsp_last_o,
  output logic                          cyc_o,
  output logic                          stb_o,
  output logic                          we_o,
  output logic [ADDR_WIDTH-1:0]         adr_o,
  output logic [DATA_WIDTH-1:0]         dat_o,
  output logic [DATA_WIDTH/GRANULE-1:0] sel_o,
  input  logic                          ack_i,
  input  logic                          err_i,
  input  logic [DATA_WIDTH-1:0]         dat_i
);

  localparam int SEL_WIDTH = sel_width(DATA_WIDTH, GRANULE);

  state_e                 state_q, state_d;
  logic                   init_q;
  logic [ADDR_WIDTH-1:0]  adr_q, adr_d;
  logic [DATA_WIDTH-1:0]  dat_q, dat_d;
  logic [SEL_WIDTH-1:0]   sel_q, sel_d;
  logic                   we_q, we_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   beat_q, beat_d;
  wb_rsp_t                rsp_p1, rsp_d;
  logic                   vld_p1, vld_d;
  logic                   accept;
  logic                   wd_clr, wd_en, wd_expire;

  // Ready only from the first clock after reset release, and only in IDLE.
  assign cmd_ready_o = init_q && (state_q == IDLE);
  assign accept      = cmd_valid_i && cmd_ready_o;

  wb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    len_d   = len_q;
    beat_d  = beat_q;
    rsp_d   = '0;
    vld_d   = 1'b0;
    wd_clr  = 1'b1;
    wd_en   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ACTIVE;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_we_i ? cmd_dat_i : '0;
          sel_d   = cmd_sel_i;
          we_d    = cmd_we_i;
          len_d   = cmd_len_i;
          beat_d  = '0;
        end
      end
      ACTIVE: begin
        wd_clr = 1'b0;
        if (err_i) begin
          vld_d       = 1'b1;
          rsp_d.err   = 1'b1;
          rsp_d.last  = 1'b1;
          state_d     = IDLE;
        end else if (ack_i) begin
          vld_d     = 1'b1;
          rsp_d.dat = we_q ? '0 : RSP_DAT_W'(dat_i);
          if (beat_q == len_q) begin
            rsp_d.last = 1'b1;
            state_d    = IDLE;
          end else begin
            adr_d  = adr_q + ADDR_WIDTH'(SEL_WIDTH);
            dat_d  = we_q ? dat_q + DATA_WIDTH'(1) : dat_q;
            beat_d = beat_q + LEN_WIDTH'(1);
            wd_clr = 1'b1;
          end
        end else begin
          wd_en = 1'b1;
          if (wd_expire) begin
            vld_d         = 1'b1;
            rsp_d.timeout = 1'b1;
            rsp_d.last    = 1'b1;
            state_d       = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
    end
  end

  // Bus-side registers: every output is cleared by reset so an in-flight
  // cycle vanishes immediately.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      adr_q  <= '0;
      dat_q  <= '0;
      sel_q  <= '0;
      we_q   <= 1'b0;
      len_q  <= '0;
      beat_q <= '0;
    end else begin
      adr_q  <= adr_d;
      dat_q  <= dat_d;
      sel_q  <= sel_d;
      we_q   <= we_d;
      len_q  <= len_d;
      beat_q <= beat_d;
    end
  end

  // ---- stage p1: response registered one cycle after the terminating edge
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld_p1 <= 1'b0;
      rsp_p1 <= '0;
    end else begin
      vld_p1 <= vld_d;
      rsp_p1 <= rsp_d;
    end
  end

  assign cyc_o         = (state_q == ACTIVE);
  assign stb_o         = (state_q == ACTIVE);
  assign we_o          = we_q;
  assign adr_o         = adr_q;
  assign dat_o         = dat_q;
  assign sel_o         = sel_q;
  assign rsp_valid_o   = vld_p1;
  assign rsp_dat_o     = DATA_WIDTH'(rsp_p1.dat);
  assign rsp_err_o     = rsp_p1.err;
  assign rsp_timeout_o = rsp_p1.timeout;
  assign rsp_last_o    = rsp_p1.last;

endmodule

// File: tb/tb_wb_master_seq.sv
module tb_wb_master_seq;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [15:0] cmd_adr_i = '0;
  logic [31:0] cmd_dat_i = '0;
  logic [3:0]  cmd_sel_i = '0;
  logic [3:0]  cmd_len_i = '0;
  logic        rsp_valid_o;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o, rsp_timeout_o, rsp_last_o;
  logic        cyc_o, stb_o, we_o;
  logic [15:0] adr_o;
  logic [31:0] dat_o;
  logic [3:0]  sel_o;
  logic        ack_i, err_i;
  logic [31:0] dat_i;

  // Slave model controls
  logic        ack_en = 1'b1;
  logic        err_en = 1'b0;
  logic [15:0] err_adr = '0;
  logic        fixed_en = 1'b0;
  logic        ack_force = 1'b0;

  always #5 clk = ~clk;

  assign ack_i = (stb_o && ack_en) || ack_force;
  assign err_i = stb_o && err_en && (adr_o == err_adr);
  assign dat_i = fixed_en ? 32'hDEADBEEF : {16'hA5A5, adr_o};

  wb_master_seq dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_we_i      (cmd_we_i),
    .cmd_adr_i     (cmd_adr_i),
    .cmd_dat_i     (cmd_dat_i),
    .cmd_sel_i     (cmd_sel_i),
    .cmd_len_i     (cmd_len_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_dat_o     (rsp_dat_o),
    .rsp_err_o     (rsp_err_o),
    .rsp_timeout_o (rsp_timeout_o),
    .rsp_last_o    (rsp_last_o),
    .cyc_o         (cyc_o),
    .stb_o         (stb_o),
    .we_o          (we_o),
    .adr_o         (adr_o),
    .dat_o         (dat_o),
    .sel_o         (sel_o),
    .ack_i         (ack_i),
    .err_i         (err_i),
    .dat_i         (dat_i)
  );

  typedef struct {
    logic [31:0] dat;
    logic        err;
    logic        to;
    logic        last;
  } exp_rsp_t;

  typedef struct {
    logic [15:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
  } exp_beat_t;

  exp_rsp_t  rsp_sb[$];
  exp_beat_t beat_sb[$];

  int n_cmp = 0;
  int n_mis = 0;
  int stb_cycles = 0;
  int rsp_cnt = 0;
  int last_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] slave_rdata(input logic [15:0] a);
    return fixed_en ? 32'hDEADBEEF : {16'hA5A5, a};
  endfunction

  // Scoreboard consumers: responses and terminated bus beats.
  always @(negedge clk) begin
    if (rst_i) begin
      if (stb_o) stb_cycles++;
      if (rsp_valid_o) begin
        rsp_cnt++;
        if (rsp_last_o) last_cnt++;
        if (rsp_sb.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          exp_rsp_t e;
          e = rsp_sb.pop_front();
          check("rsp_dat", rsp_dat_o, e.dat);
          check("rsp_err", rsp_err_o, e.err);
          check("rsp_timeout", rsp_timeout_o, e.to);
          check("rsp_last", rsp_last_o, e.last);
        end
      end
      if (cyc_o && stb_o && (ack_i || err_i)) begin
        if (beat_sb.size() == 0) begin
          check("beat_unexpected", 1, 0);
        end else begin
          exp_beat_t b;
          b = beat_sb.pop_front();
          check("bus_adr", adr_o, b.adr);
          check("bus_dat", dat_o, b.dat);
          check("bus_we", we_o, b.we);
          check("bus_sel", sel_o, b.sel);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [15:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [3:0] len);
    bit got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready_o) begin
        got = 1;
        break;
      end
    end
    if (!got) check("cmd_ready_wait", 0, 1);
    // Reference model of the whole command against the current slave setup.
    for (int k = 0; k <= int'(len); k++) begin
      logic [15:0] a;
      exp_beat_t   b;
      exp_rsp_t    r;
      a     = adr + 16'(k * 4);
      b.adr = a;
      b.dat = we ? dat + 32'(k) : 32'h0;
      b.we  = we;
      b.sel = sel;
      if (err_en && a == err_adr) begin
        beat_sb.push_back(b);
        r = '{dat: 32'h0, err: 1'b1, to: 1'b0, last: 1'b1};
        rsp_sb.push_back(r);
        break;
      end else if (ack_en) begin
        beat_sb.push_back(b);
        r = '{dat: (we ? 32'h0 : slave_rdata(a)), err: 1'b0, to: 1'b0, last: (k == int'(len))};
        rsp_sb.push_back(r);
      end else begin
        r = '{dat: 32'h0, err: 1'b0, to: 1'b1, last: 1'b1};
        rsp_sb.push_back(r);
        break;
      end
    end
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_dat_i   = dat;
    cmd_sel_i   = sel;
    cmd_len_i   = len;
    @(posedge clk);
    #1;
    // Junk on the command fields must not matter after acceptance.
    cmd_valid_i = 1'b0;
    cmd_we_i    = 1'($urandom);
    cmd_adr_i   = 16'($urandom);
    cmd_dat_i   = $urandom;
    cmd_sel_i   = 4'($urandom);
    cmd_len_i   = 4'($urandom);
  endtask

  task automatic wait_done(input string tag);
    bit done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rsp_sb.size() == 0 && !cyc_o) begin
        done = 1;
        break;
      end
    end
    if (!done) check({tag, "_wait"}, 0, 1);
    check({tag, "_beats_left"}, 64'(beat_sb.size()), 0);
  endtask

  task automatic clear_counts();
    stb_cycles = 0;
    rsp_cnt    = 0;
    last_cnt   = 0;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_cyc", cyc_o, 0);
    check("rst_stb", stb_o, 0);
    check("rst_ready", cmd_ready_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    #1;
    check("ready_before_clock", cmd_ready_o, 0);
    @(negedge clk);
    check("ready_after_clock", cmd_ready_o, 1);

    // Single read with exact latency
    clear_counts();
    fixed_en = 1'b1;
    issue(1'b0, 16'h0010, 32'h0, 4'hF, 4'd0);
    @(negedge clk);
    check("single_stb", stb_o, 1);
    check("single_ready_busy", cmd_ready_o, 0);
    @(negedge clk);
    check("single_rsp_valid", rsp_valid_o, 1);
    check("single_cyc_dropped", cyc_o, 0);
    check("single_ready_back", cmd_ready_o, 1);
    wait_done("single");
    check("single_stb_cycles", 64'(stb_cycles), 1);
    fixed_en = 1'b0;

    // 4-beat write
    clear_counts();
    issue(1'b1, 16'h0100, 32'h5, 4'hF, 4'd3);
    wait_done("wr4");
    check("wr4_stb_cycles", 64'(stb_cycles), 4);
    check("wr4_rsp_cnt", 64'(rsp_cnt), 4);
    check("wr4_last_cnt", 64'(last_cnt), 1);

    // Error abort on beat 1 (err and ack together)
    clear_counts();
    err_en  = 1'b1;
    err_adr = 16'h0204;
    issue(1'b0, 16'h0200, 32'h0, 4'h3, 4'd2);
    wait_done("err");
    check("err_stb_cycles", 64'(stb_cycles), 2);
    check("err_rsp_cnt", 64'(rsp_cnt), 2);
    err_en = 1'b0;

    // Timeout with a late ack on cycle 20
    clear_counts();
    ack_en = 1'b0;
    issue(1'b0, 16'h0300, 32'h0, 4'hF, 4'd0);
    repeat (19) @(negedge clk);
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    wait_done("timeout");
    repeat (3) @(negedge clk);
    check("timeout_stb_cycles", 64'(stb_cycles), 16);
    check("timeout_rsp_cnt", 64'(rsp_cnt), 1);
    ack_en = 1'b1;

    // Address wrap
    clear_counts();
    issue(1'b0, 16'hFFFC, 32'h0, 4'hF, 4'd1);
    wait_done("wrap");
    check("wrap_rsp_cnt", 64'(rsp_cnt), 2);

    // Random-ish reads and writes through the scoreboard
    for (int t = 0; t < 4; t++) begin
      issue(1'($urandom), 16'($urandom), $urandom, 4'($urandom), 4'($urandom_range(0, 5)));
      wait_done("rand");
    end

    // Mid-cycle reset during beat 2 of 4
    clear_counts();
    issue(1'b1, 16'h0400, 32'h10, 4'hF, 4'd3);
    repeat (3) @(negedge clk);
    #2;
    rst_i = 1'b0;
    #1;
    check("midrst_cyc", cyc_o, 0);
    check("midrst_stb", stb_o, 0);
    check("midrst_rsp_valid", rsp_valid_o, 0);
    check("midrst_ready", cmd_ready_o, 0);
    rsp_sb.delete();
    beat_sb.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("midrst_hold_rsp", rsp_valid_o, 0);
    end
    rst_i = 1'b1;
    clear_counts();
    issue(1'b0, 16'h0500, 32'h0, 4'hF, 4'd0);
    wait_done("post_rst");
    check("post_rst_rsp_cnt", 64'(rsp_cnt), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/wb_master_seq.md
Name: wb_master_seq

Overview:
- Command-driven Wishbone classic initiator: the initiating end of the bus that the slave-side blocks answer.
- Accepts a command (read/write, address, data, select, beat count) and runs one classic cycle of 1..2^LEN_WIDTH beats with incrementing address.
- Returns one response per beat; aborts on err_i or on a per-beat timeout.
- Sits on any master port of wb_intercon and serves as the standard traffic source for slave benches and system tests.

Parameters:
- ADDR_WIDTH, 16, Wishbone address width.
- DATA_WIDTH, 32, Wishbone data width.
- GRANULE, 8, bits per select lane. SEL_WIDTH = DATA_WIDTH/GRANULE; DATA_WIDTH must be a multiple of GRANULE.
- LEN_WIDTH, 4, command beat-count width; beats = cmd_len+1.
- TIMEOUT_CYCLES, 16, maximum cycles per beat without ack_i/err_i; 0 disables the timeout.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when both valid and ready are high.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  ADDR_WIDTH  start address.
- cmd_dat_i  in  DATA_WIDTH  write data for beat 0.
- cmd_sel_i  in  SEL_WIDTH  byte select, applied to all beats.
- cmd_len_i  in  LEN_WIDTH  beat count minus 1.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_dat_o  out  DATA_WIDTH  captured dat_i; 0 for writes, err and timeout.
- rsp_err_o  out  1  beat terminated by err_i.
- rsp_timeout_o  out  1  beat timed out.
- rsp_last_o  out  1  final response of the command.
- cyc_o, stb_o, we_o  out  1 each  Wishbone controls.
- adr_o  out  ADDR_WIDTH  Wishbone address.
- dat_o  out  DATA_WIDTH  Wishbone write data.
- sel_o  out  SEL_WIDTH  Wishbone select.
- ack_i, err_i  in  1 each  Wishbone terminations.
- dat_i  in  DATA_WIDTH  Wishbone read data.

Behaviour:
- Reset (asynchronous, rst_i=0):
  - All outputs go to 0 immediately, except cmd_ready_o, which is 0 while rst_i=0 and 1 from the first clock after release.
  - Any in-flight cycle is dropped without a response.
- States: IDLE, ACTIVE.
- IDLE:
  - cmd_ready_o=1, cyc_o=stb_o=0.
  - On valid&&ready, latch the command. The next cycle enters ACTIVE with cyc_o=stb_o=1, adr_o=cmd_adr, dat_o=cmd_dat (writes; 0 for reads), sel_o and we_o as commanded, beat=0, timer=0.
- ACTIVE: cmd_ready_o=0. Each rising edge samples the terminations, with err_i taking priority over ack_i when both are high:
  - err_i: register a response with err=1 and last=1; drop cyc/stb on the next cycle; return to IDLE.
  - ack_i on a non-final beat:
    - Register a response with last=0.
    - Next cycle: adr_o += SEL_WIDTH (wraps modulo 2^ADDR_WIDTH), dat_o += 1 (wraps) for writes, beat += 1, timer=0.
    - cyc/stb stay high, so there are no idle cycles between beats.
  - ack_i on the final beat (beat==cmd_len): register a response with last=1; drop cyc/stb; return to IDLE.
  - Neither termination: timer += 1. If TIMEOUT_CYCLES!=0 and the timer reaches TIMEOUT_CYCLES, register a response with timeout=1 and last=1; drop cyc/stb; return to IDLE. Any ack arriving after the drop is ignored.
- Response timing:
  - rsp_valid_o is high for exactly 1 cycle, in the cycle after the terminating edge.
  - rsp_dat_o holds dat_i as sampled at that edge for read acks.
  - There is no response back-pressure.
- Throughput:
  - Minimum 1 IDLE cycle between cycles; a new command is accepted in the cycle rsp_last is shown.
  - Single-beat latency: accept edge, then stb high, then ack edge, then rsp_valid: 3 clocks with a combinational-ack slave.
- Bus outputs are stable while stb_o is high and the beat is unterminated.
- cmd_* inputs are ignored outside the accept cycle.

Decomposition:
- Shared package wb_pkg:
  - State enum state_e {IDLE, ACTIVE}.
  - Packed struct wb_rsp_t {dat, err, timeout, last}.
  - Function sel_width(DATA_WIDTH, GRANULE).
- One natural sub-module: wb_watchdog.
  - Per-beat timeout counter with clear, enable and expire.
  - Width $clog2(TIMEOUT_CYCLES+1).
  - Tied off when TIMEOUT_CYCLES=0.

Test Plan:
- Single read: read adr 0x0010 from a slave with combinational ack returning 0xDEADBEEF.
  - Expect cyc/stb high for 1 cycle.
  - Expect one rsp: dat=0xDEADBEEF, last=1, err=0.
  - Expect cmd_ready back 1 cycle later.
- 4-beat write: write adr 0x0100, dat 0x00000005, sel 0xF, len 3.
  - Expect adr_o sequence 0x0100/0x0104/0x0108/0x010C with dat_o 5/6/7/8.
  - Expect cyc held for 4 cycles, 4 rsp pulses, last only on the 4th.
- Error abort: 3-beat read where the slave asserts err_i together with ack_i on beat 1.
  - Expect 2 rsps, the second with err=1, last=1.
  - Expect cyc dropped with no beat 2.
- Timeout: TIMEOUT_CYCLES=16 with a slave that never acks.
  - Expect stb held for exactly 16 cycles.
  - Expect rsp timeout=1, last=1; a late ack_i on cycle 20 is ignored.
- Address wrap: read adr 0xFFFC, len 1.
  - Expect the second beat at adr 0x0000.
- Mid-cycle reset: rst_i low during beat 2 of 4.
  - Expect cyc/stb 0 without waiting for a clock edge and no rsp_valid.
  - After release, the first command is accepted cleanly.
